cpu_trace_monitor: RTL
======================

// Module: cpu_trace_monitor
// PURPOSE
//   Run-control and trace monitor for CPU simulation/bring-up. Watches CHANNELS WIDTH-bit CPU
//   signals (e.g. result, pc), logs each value change with a cycle timestamp into a DEPTH-entry
//   trace FIFO read out by valid/ready, and ends the run on a cycle-limit timeout or on halt
//   detection (channel 0 stable). Sits beside cpu; replaces the fixed-length print-every-cycle bench loop.
// PARAMETERS
//   WIDTH       32    bits per watched channel
//   CHANNELS    2     watched channels, 1..8; channel c = mon_data[c*WIDTH +: WIDTH]
//   DEPTH       16    trace FIFO entries, power of 2, >=2
//   TS_WIDTH    16    timestamp bits (low bits of cycle_count)
//   MAX_CYCLES  1000  run cycles before timeout, >=1
//   HALT_CYCLES 8     consecutive unchanged ch0 cycles signalling halt, >=1
// PORTS
//   clk          in   1                 clock, all logic on rising edge
//   rst          in   1                 reset, synchronous, active-high
//   en           in   1                 run enable; low pauses counting and sampling
//   mon_data     in   CHANNELS*WIDTH    watched CPU signals
//   rd_valid     out  1                 trace head entry available (= FIFO not empty)
//   rd_ready     in   1                 consumer pops head when rd_valid & rd_ready
//   rd_data      out  WIDTH             head entry value
//   rd_chan      out  max(1,$clog2(CHANNELS))  head entry channel index
//   rd_ts        out  TS_WIDTH          head entry timestamp
//   cycle_count  out  32                RUN cycles elapsed with en=1
//   running      out  1                 state == RUN
//   done         out  1                 state == DONE
//   done_reason  out  2                 0 none, 1 timeout, 2 halt
//   drop_count   out  16                trace entries lost to full FIFO, saturates at 16'hFFFF
// BEHAVIOUR
//   Reset: state IDLE; FIFO empty; cycle_count, drop_count, done_reason, running, done, rd_* = 0;
//     prev[] = 0; stable count = 0. rst has priority over everything, incl. mid-run.
//   FSM IDLE->RUN on en=1: prev[c] <= mon_data[c] for all c, no entry, cycle_count stays 0.
//   RUN with en=1 each cycle: cycle_count++; changed[c] = mon_data[c] != prev[c];
//     lowest changed c recorded {ts=cycle_count[TS_WIDTH-1:0] (pre-increment), chan=c, data},
//     prev[c] updated; other changed channels stay pending, recorded on later cycles (one per cycle);
//     a value that reverts before recording is not logged.
//   RUN with en=0: nothing updates; FIFO still pops.
//   Halt: stable count increments while changed[0]=0, clears on change; reaching HALT_CYCLES -> DONE, reason 2.
//   Timeout: cycle_count reaching MAX_CYCLES (on increment) -> DONE, reason 1. Both same cycle: reason 2.
//   DONE: absorbing until rst; no sampling/counting; FIFO remains readable.
//   Latency: entry recorded at edge t gives rd_valid=1 after edge t (show-ahead head, rd_* combinational from head).
//   FIFO: full = DEPTH entries. Push+pop same cycle when full: both succeed, occupancy unchanged.
//     Pop when empty ignored. Pointers wrap modulo DEPTH.
// CONFIGURATION
//   TRACE_OVERWRITE_EN defined: push when full and no pop overwrites oldest (head advances),
//     drop_count++ (entry lost is the oldest); newest entry always kept.
//   Undefined (default): push when full and no pop discarded, drop_count++; FIFO contents untouched.
// STRUCTURE
//   cpu_trace_pkg: state_t {IDLE,RUN,DONE}, reason_t {R_NONE,R_TIMEOUT,R_HALT},
//     parametrised-width trace entry struct fields {ts,chan,data}, reason encodings.
//   Sub-module trace_fifo (DEPTH, entry width): ring buffer, push/pop/full/empty,
//     overwrite/drop behaviour under TRACE_OVERWRITE_EN, drop pulse to parent.
// TESTING
//   1 Reset mid-run (cycle_count=5, 3 entries) -> next cycle all outputs 0, state IDLE, rd_valid=0.
//   2 CHANNELS=2; ch0 0->1 and ch1 0->7 same cycle at cycle 3 -> entries {3,0,1} then {4,1,7}.
//   3 MAX_CYCLES=10, ch0 toggling every cycle -> done=1, done_reason=1, cycle_count=10, counting stops.
//   4 HALT_CYCLES=4, ch0 stops changing at cycle 6 -> done after 4 stable cycles, reason 2.
//   5 DEPTH=4, rd_ready=0, 6 changes -> default: first 4 kept, drop_count=2; with TRACE_OVERWRITE_EN:
//     last 4 kept, drop_count=2. Full + rd_ready=1 + change -> no drop.
//   6 en low for 3 cycles in RUN -> cycle_count frozen, no entries, halt counter held.

Source files
------------

// File: rtl/cpu_trace_pkg.sv
// Shared types and width helpers for the CPU trace monitor.
// Trace entries are laid out as {ts, chan, data}; widths come from the instantiating module.
package cpu_trace_pkg;

    localparam int unsigned CYCLE_W  = 32;
    localparam int unsigned DROP_W   = 16;
    localparam int unsigned REASON_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [REASON_W-1:0] {
        R_NONE    = 2'd0,
        R_TIMEOUT = 2'd1,
        R_HALT    = 2'd2
    } reason_t;

    // Channel index width; a single channel still carries a 1-bit index.
    function automatic int unsigned chan_width(input int unsigned channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    function automatic int unsigned entry_width(input int unsigned ts_w,
                                                input int unsigned chan_w,
                                                input int unsigned data_w);
        return ts_w + chan_w + data_w;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Ring-buffer trace FIFO with show-ahead head and a drop pulse on push-when-full.
// TRACE_OVERWRITE_EN: a push into a full FIFO evicts the oldest entry instead of the new one.
module trace_fifo #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned ENTRY_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_push,
    input  logic [ENTRY_W-1:0] i_push_data,
    input  logic               i_pop,
    output logic [ENTRY_W-1:0] o_head_c,
    output logic               o_empty_c,
    output logic               o_full_c,
    output logic               o_drop_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic w_pop_ok;
    logic w_push_ok;
    logic w_adv_head;

    assign o_empty_c = (r_count == '0);
    assign o_full_c  = (r_count == CNT_W'(DEPTH));
    assign o_head_c  = r_mem[r_rd_ptr];
    assign w_pop_ok  = i_pop & ~o_empty_c;
    // A simultaneous pop frees the slot, so only an unpopped full push is a loss.
    assign o_drop_c  = i_push & o_full_c & ~w_pop_ok;

`ifdef TRACE_OVERWRITE_EN
    assign w_push_ok  = i_push;
    assign w_adv_head = w_pop_ok | o_drop_c;
`else
    assign w_push_ok  = i_push & ~o_drop_c;
    assign w_adv_head = w_pop_ok;
`endif

    // Storage carries no reset; validity is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_adv_head) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push_ok && !w_adv_head) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_adv_head && !w_push_ok) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/cpu_trace_monitor.sv
// Run-control and trace monitor: logs watched-signal changes with timestamps, ends on timeout or halt.
// TRACE_OVERWRITE_EN selects overwrite-oldest instead of drop-newest when the trace FIFO is full.
module cpu_trace_monitor
    import cpu_trace_pkg::*;
#(
    parameter  int unsigned WIDTH       = 32,
    parameter  int unsigned CHANNELS    = 2,
    parameter  int unsigned DEPTH       = 16,
    parameter  int unsigned TS_WIDTH    = 16,
    parameter  int unsigned MAX_CYCLES  = 1000,
    parameter  int unsigned HALT_CYCLES = 8,
    localparam int unsigned CHAN_W      = chan_width(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [CHANNELS*WIDTH-1:0] mon_data,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [WIDTH-1:0]          rd_data,
    output logic [CHAN_W-1:0]         rd_chan,
    output logic [TS_WIDTH-1:0]       rd_ts,
    output logic [CYCLE_W-1:0]        cycle_count,
    output logic                      running,
    output logic                      done,
    output logic [REASON_W-1:0]       done_reason,
    output logic [DROP_W-1:0]         drop_count
);

    localparam int unsigned STAB_W  = $clog2(HALT_CYCLES + 1);
    localparam int unsigned ENTRY_W = entry_width(TS_WIDTH, CHAN_W, WIDTH);

    typedef struct packed {
        logic [TS_WIDTH-1:0] ts;
        logic [CHAN_W-1:0]   chan;
        logic [WIDTH-1:0]    data;
    } entry_t;

    state_t             r_state;
    state_t             w_next_state;
    reason_t            r_reason;
    reason_t            w_next_reason;
    logic [CYCLE_W-1:0] r_cycle_count;
    logic [STAB_W-1:0]  r_stable;
    logic [DROP_W-1:0]  r_drop;
    logic [WIDTH-1:0]   r_prev [CHANNELS];

    logic [CHANNELS-1:0] w_changed;
    logic                w_any;
    logic [CHAN_W-1:0]   w_sel;
    logic [WIDTH-1:0]    w_sel_data;
    logic                w_active;
    logic                w_push;
    logic [CYCLE_W-1:0]  w_cycle_inc;
    logic [STAB_W-1:0]   w_stable_inc;
    logic                w_halt;
    logic                w_timeout;
    entry_t              w_push_entry;
    entry_t              w_head;
    logic                w_empty;
    logic                w_full;
    logic                w_drop;

    assign w_active     = (r_state == RUN) && en;
    assign w_cycle_inc  = r_cycle_count + CYCLE_W'(1);
    assign w_stable_inc = r_stable + STAB_W'(1);
    assign w_halt       = ~w_changed[0] && (w_stable_inc == STAB_W'(HALT_CYCLES));
    assign w_timeout    = (w_cycle_inc == CYCLE_W'(MAX_CYCLES));

    // Change detection and lowest-index pick; unrecorded changes stay pending against r_prev.
    always_comb begin
        w_changed  = '0;
        w_any      = 1'b0;
        w_sel      = '0;
        w_sel_data = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_changed[c] = (mon_data[c*WIDTH +: WIDTH] != r_prev[c]);
        end
        for (int c = CHANNELS - 1; c >= 0; c--) begin
            if (w_changed[c]) begin
                w_any      = 1'b1;
                w_sel      = CHAN_W'(c);
                w_sel_data = mon_data[c*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        w_push_entry.ts   = r_cycle_count[TS_WIDTH-1:0];
        w_push_entry.chan = w_sel;
        w_push_entry.data = w_sel_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state, done reason and trace push; halt wins when both end conditions coincide.
    always_comb begin
        w_next_state  = r_state;
        w_next_reason = r_reason;
        w_push        = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (en) begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                if (en) begin
                    w_push = w_any;
                    if (w_halt) begin
                        w_next_state  = DONE;
                        w_next_reason = R_HALT;
                    end else if (w_timeout) begin
                        w_next_state  = DONE;
                        w_next_reason = R_TIMEOUT;
                    end
                end
            end
            DONE: begin
                w_next_state = DONE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_reason      <= R_NONE;
            r_cycle_count <= '0;
            r_stable      <= '0;
            r_drop        <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                r_prev[c] <= '0;
            end
        end else begin
            r_reason <= w_next_reason;
            if ((r_state == IDLE) && en) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    r_prev[c] <= mon_data[c*WIDTH +: WIDTH];
                end
            end
            if (w_active) begin
                r_cycle_count <= w_cycle_inc;
                r_stable      <= w_changed[0] ? '0 : w_stable_inc;
                for (int c = 0; c < CHANNELS; c++) begin
                    if (w_any && (w_sel == CHAN_W'(c))) begin
                        r_prev[c] <= w_sel_data;
                    end
                end
            end
            if (w_drop && (r_drop != '1)) begin
                r_drop <= r_drop + DROP_W'(1);
            end
        end
    end

    trace_fifo #(
        .DEPTH   (DEPTH),
        .ENTRY_W (ENTRY_W)
    ) u_trace_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (rd_ready),
        .o_head_c    (w_head),
        .o_empty_c   (w_empty),
        .o_full_c    (w_full),
        .o_drop_c    (w_drop)
    );

    // Head fields read as zero while the FIFO is empty.
    assign rd_valid    = ~w_empty;
    assign rd_data     = w_empty ? '0 : w_head.data;
    assign rd_chan     = w_empty ? '0 : w_head.chan;
    assign rd_ts       = w_empty ? '0 : w_head.ts;
    assign cycle_count = r_cycle_count;
    assign running     = (r_state == RUN);
    assign done        = (r_state == DONE);
    assign done_reason = r_reason;
    assign drop_count  = r_drop;

    logic w_unused;
    assign w_unused = w_full;

endmodule
